// File: rtl/baud_pkg.sv
// ---------------------------------------------------------------------------
// baud_pkg
//   Shared constants for the fractional baud tick generator: default widths,
//   oversample ratio and the reset divisor. The reset divisor is the worked
//   example of a 50 MHz clock driving 19200 baud at x16 oversampling.
//   Divisor value in 1/2^FRAC_W clock units = CLK * 2^FRAC_W / (BAUD * OVS).
//   That gives 2604 = 162*16 + 12, so div_int = 162-1 = 161 and div_frac = 12.
// ---------------------------------------------------------------------------
package baud_pkg;

  localparam int DIV_W_DEF  = 16;
  localparam int FRAC_W_DEF = 4;
  localparam int OVS_DEF    = 16;

  localparam int EX_CLK_HZ   = 50_000_000;
  localparam int EX_BAUD     = 19_200;
  localparam int EX_DIV_Q    = (EX_CLK_HZ * (2 ** FRAC_W_DEF)) / (EX_BAUD * OVS_DEF);
  localparam int EX_DIV_INT  = (EX_DIV_Q / (2 ** FRAC_W_DEF)) - 1;
  localparam int EX_DIV_FRAC = EX_DIV_Q % (2 ** FRAC_W_DEF);

  localparam int RST_DIV_INT_DEF  = EX_DIV_INT;
  localparam int RST_DIV_FRAC_DEF = EX_DIV_FRAC;

endpackage

// File: rtl/baud_tick_gen_frac_div.sv
// ---------------------------------------------------------------------------
// frac_period_div
//   Fractional period divider. Produces one registered os_tick per period,
//   where a period is div_int+1+carry cycles and carry comes from a FRAC_W-bit
//   phase accumulator stepped by div_frac once per period.
// Ports
//   clk, reset    clock, synchronous active-low reset
//   en            1 = count, 0 = hold cnt/acc, no ticks
//   restart       zero cnt and acc (priority over en), no tick
//   div_int       active integer divisor
//   div_frac      active fractional divisor
//   os_tick       registered tick, one cycle per period
//   tick_next     os_tick value for the next cycle (used by the top to
//                 apply a pending divisor and advance ovs_cnt in step)
// ---------------------------------------------------------------------------
module frac_period_div
  import baud_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              restart,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick,
  output logic              tick_next
);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              ext_q, ext_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              os_tick_q, os_tick_d;
  logic [FRAC_W:0]   acc_sum_s;
  logic [DIV_W:0]    limit_s;
  logic [DIV_W:0]    pos_s;
  logic              carry_s;
  logic              at_end_s;

  // Period bookkeeping: end-of-period detect, counter/accumulator next state.
  always_comb begin
    // acc_q and the active divisor are stable within a period, so the carry
    // computed here is the one belonging to the period start.
    acc_sum_s = {1'b0, acc_q} + {1'b0, div_frac};
    carry_s   = acc_sum_s[FRAC_W];
    limit_s   = {1'b0, div_int} + {{DIV_W{1'b0}}, carry_s};
    // ext_q extends cnt by one count so div_int = 2^DIV_W-1 with carry fits.
    pos_s     = {1'b0, cnt_q} + {{DIV_W{1'b0}}, ext_q};
    // >= rather than == keeps the counter bounded if the divisor shrinks
    // while frozen.
    at_end_s  = (pos_s >= limit_s);

    cnt_d     = cnt_q;
    ext_d     = ext_q;
    acc_d     = acc_q;
    os_tick_d = 1'b0;

    if (restart) begin
      cnt_d = {DIV_W{1'b0}};
      ext_d = 1'b0;
      acc_d = {FRAC_W{1'b0}};
    end else if (en) begin
      if (at_end_s) begin
        cnt_d     = {DIV_W{1'b0}};
        ext_d     = 1'b0;
        acc_d     = acc_sum_s[FRAC_W-1:0];
        os_tick_d = 1'b1;
      end else if (&cnt_q) begin
        ext_d = 1'b1;
      end else begin
        cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end

    tick_next = os_tick_d;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= {DIV_W{1'b0}};
      ext_q     <= 1'b0;
      acc_q     <= {FRAC_W{1'b0}};
      os_tick_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ext_q     <= ext_d;
      acc_q     <= acc_d;
      os_tick_q <= os_tick_d;
    end
  end

  assign os_tick = os_tick_q;

endmodule

// File: rtl/baud_tick_gen_frac.sv
// ---------------------------------------------------------------------------
// baud_tick_gen_frac
//   UART baud tick generator with fractional divisor. Emits the oversample
//   tick plus mid-bit and bit ticks derived from an OVS-wide oversample count.
//   New divisors go through a shadow register and only become active on a
//   period boundary (or immediately while stopped), so no period mixes two
//   divisors.
// Ports
//   clk, reset    clock, synchronous active-low reset
//   en            1 = run, 0 = freeze counters, no ticks
//   restart       1-cycle pulse, realign phase (cnt, acc, ovs_cnt to 0)
//   div_int       new integer divisor, captured on div_load
//   div_frac      new fractional divisor, captured on div_load
//   div_load      1-cycle pulse, capture divisor into shadow
//   cfg_pending   shadow holds a divisor not yet active
//   os_tick       oversample tick
//   mid_tick      os_tick with pre-increment ovs_cnt == OVS/2-1
//   bit_tick      os_tick with pre-increment ovs_cnt == OVS-1
// ---------------------------------------------------------------------------
module baud_tick_gen_frac
  import baud_pkg::*;
#(
  parameter int DIV_W        = DIV_W_DEF,
  parameter int FRAC_W       = FRAC_W_DEF,
  parameter int OVS          = OVS_DEF,
  parameter int RST_DIV_INT  = RST_DIV_INT_DEF,
  parameter int RST_DIV_FRAC = RST_DIV_FRAC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              restart,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              cfg_pending,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick
);

  localparam int                OVS_W    = $clog2(OVS);
  localparam logic [OVS_W-1:0]  OVS_MID  = OVS_W'(OVS / 2 - 1);
  localparam logic [OVS_W-1:0]  OVS_LAST = OVS_W'(OVS - 1);
  localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(RST_DIV_INT);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RST_DIV_FRAC);

  logic [DIV_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [DIV_W-1:0]  shd_int_q, shd_int_d;
  logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
  logic              pend_q, pend_d;
  logic [OVS_W-1:0]  ovs_cnt_q, ovs_cnt_d;
  logic              mid_tick_q, mid_tick_d;
  logic              bit_tick_q, bit_tick_d;
  logic              tick_next_s;
  logic              apply_s;

  frac_period_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .restart   (restart),
    .div_int   (act_int_q),
    .div_frac  (act_frac_q),
    .os_tick   (os_tick),
    .tick_next (tick_next_s)
  );

  // Shadow/apply control, oversample counter and mid/bit tick qualification.
  always_comb begin
    // Apply on the edge that raises os_tick so the following period is the
    // first to see the new divisor; while stopped there is no period to
    // protect, so apply straight away. restart leaves the divisor alone.
    apply_s    = pend_q & ~restart & (tick_next_s | ~en);

    act_int_d  = apply_s ? shd_int_q  : act_int_q;
    act_frac_d = apply_s ? shd_frac_q : act_frac_q;
    shd_int_d  = div_load ? div_int  : shd_int_q;
    shd_frac_d = div_load ? div_frac : shd_frac_q;
    // A load coinciding with apply wins: the fresh value stays pending.
    pend_d     = div_load | (pend_q & ~apply_s);

    if (restart) begin
      ovs_cnt_d = {OVS_W{1'b0}};
    end else if (tick_next_s) begin
      ovs_cnt_d = (ovs_cnt_q == OVS_LAST) ? {OVS_W{1'b0}} : ovs_cnt_q + OVS_W'(1);
    end else begin
      ovs_cnt_d = ovs_cnt_q;
    end

    mid_tick_d = tick_next_s & (ovs_cnt_q == OVS_MID);
    bit_tick_d = tick_next_s & (ovs_cnt_q == OVS_LAST);
  end

  // Configuration and tick registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      act_int_q  <= RST_INT;
      act_frac_q <= RST_FRAC;
      shd_int_q  <= {DIV_W{1'b0}};
      shd_frac_q <= {FRAC_W{1'b0}};
      pend_q     <= 1'b0;
      ovs_cnt_q  <= {OVS_W{1'b0}};
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      pend_q     <= pend_d;
      ovs_cnt_q  <= ovs_cnt_d;
      mid_tick_q <= mid_tick_d;
      bit_tick_q <= bit_tick_d;
    end
  end

  assign cfg_pending = pend_q;
  assign mid_tick    = mid_tick_q;
  assign bit_tick    = bit_tick_q;

endmodule
